// File: rtl/fog_rdout_pkg.sv
// Shared types for the FOG readout streamer: frame layout, FSM states, header fields.
// FOG_RDOUT_CHKSUM_EN adds a checksum word (W_CHK) to every frame.
package fog_rdout_pkg;

    typedef struct packed {
        logic [15:0] seq;
        logic        ovf;
        logic [31:0] err;
        logic [31:0] step;
        logic [31:0] ramp;
    } frame_t;

`ifdef FOG_RDOUT_CHKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HDR, W_ERR, W_STEP, W_RAMP, W_CHK
    } rdout_state_e;
    localparam int FRAME_WORDS = 5;
`else
    typedef enum logic [2:0] {
        IDLE, HDR, W_ERR, W_STEP, W_RAMP
    } rdout_state_e;
    localparam int FRAME_WORDS = 4;
`endif

    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_OVF_BIT  = 23;
    localparam int HDR_SEQ_LSB  = 0;

    // Header word: {sync, ovf, 7'b0, seq}
    function automatic logic [31:0] make_hdr(input logic [7:0] sync,
                                             input frame_t     f);
        logic [31:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8] = sync;
        h[HDR_OVF_BIT]       = f.ovf;
        h[HDR_SEQ_LSB +: 16] = f.seq;
        return h;
    endfunction

endpackage

// File: rtl/fog_rdout_fifo.sv
// Synchronous frame FIFO; exposes head and the entry behind it so the
// streamer can start the next frame on the same edge the head is popped.
module fog_rdout_fifo
    import fog_rdout_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  frame_t                 i_wr_data,
    input  logic                   i_rd_en,
    output frame_t                 o_head,
    output frame_t                 o_next,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    frame_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     count_q, count_d;

    // Pointer and occupancy update for push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (i_rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({i_wr_en, i_rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame storage, no reset needed
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign o_head  = mem_q[rd_ptr_q];
    assign o_next  = mem_q[rd_nxt];
    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/fog_readout_streamer.sv
// Snapshots FOG loop outputs on the step trigger, buffers frames, streams them.
// FOG_RDOUT_CHKSUM_EN appends header^err^step^ramp as a fifth word.
module fog_readout_streamer
    import fog_rdout_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic [15:0]                 i_dec,
    input  logic                        i_trig,
    input  logic [31:0]                 i_err,
    input  logic [31:0]                 i_step,
    input  logic [31:0]                 i_ramp,
    output logic [31:0]                 o_tdata,
    output logic                        o_tvalid,
    input  logic                        i_tready,
    output logic                        o_tlast,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic [15:0]                 o_drop_cnt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef FOG_RDOUT_CHKSUM_EN
    localparam rdout_state_e LAST_ST = W_CHK;
`else
    localparam rdout_state_e LAST_ST = W_RAMP;
`endif

    logic [15:0]  dec_q, dec_d;
    logic [15:0]  seq_q, seq_d;
    logic         ovf_q, ovf_d;
    logic [15:0]  drop_q, drop_d;
    rdout_state_e state_q, state_d;
    logic [31:0]  tdata_q, tdata_d;
    logic         tvalid_q, tvalid_d;
    logic         tlast_q, tlast_d;

    frame_t       wr_frame, head, nxt;
    logic         fifo_full, fifo_empty;
    logic [LW-1:0] fifo_count;
    logic         cap, hs, pop, accept, drop;

    assign cap    = i_en && i_trig && (dec_q == '0);
    assign hs     = tvalid_q && i_tready;
    assign pop    = hs && (state_q == LAST_ST);
    assign accept = cap && (!fifo_full || pop);
    assign drop   = cap && !accept;

    // Decimation counter: capture on zero, reload with i_dec
    always_comb begin
        dec_d = dec_q;
        if (!i_en)
            dec_d = '0;
        else if (i_trig)
            dec_d = (dec_q == '0) ? i_dec : dec_q - 16'd1;
    end

    // Sequence, sticky overflow and saturating drop count
    always_comb begin
        seq_d  = seq_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (accept) begin
            seq_d = seq_q + 16'd1;
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    // Frame snapshot written on the edge that ends the trigger cycle
    always_comb begin
        wr_frame      = '0;
        wr_frame.seq  = seq_q;
        wr_frame.ovf  = ovf_q;
        wr_frame.err  = i_err;
        wr_frame.step = i_step;
        wr_frame.ramp = i_ramp;
    end

    fog_rdout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (accept),
        .i_wr_data (wr_frame),
        .i_rd_en   (pop),
        .o_head    (head),
        .o_next    (nxt),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    // Stream FSM: next registered word chosen from the FIFO head
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        unique case (state_q)
            IDLE: if (!fifo_empty) begin
                state_d  = HDR;
                tdata_d  = make_hdr(SYNC_BYTE, head);
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
            end
            HDR: if (hs) begin
                state_d = W_ERR;
                tdata_d = head.err;
            end
            W_ERR: if (hs) begin
                state_d = W_STEP;
                tdata_d = head.step;
            end
            W_STEP: if (hs) begin
                state_d = W_RAMP;
                tdata_d = head.ramp;
                tlast_d = (LAST_ST == W_RAMP);
            end
`ifdef FOG_RDOUT_CHKSUM_EN
            W_RAMP: if (hs) begin
                state_d = W_CHK;
                tdata_d = make_hdr(SYNC_BYTE, head)
                          ^ head.err ^ head.step ^ head.ramp;
                tlast_d = 1'b1;
            end
            W_CHK: state_d = W_CHK;
`else
            W_RAMP: state_d = W_RAMP;
`endif
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
        // Frame end: chain straight into the next buffered frame
        if (pop) begin
            if (fifo_count > LW'(1)) begin
                state_d  = HDR;
                tdata_d  = make_hdr(SYNC_BYTE, nxt);
                tvalid_d = 1'b1;
            end else begin
                state_d  = IDLE;
                tdata_d  = '0;
                tvalid_d = 1'b0;
            end
            tlast_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dec_q    <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            state_q  <= IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            dec_q    <= dec_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign o_tdata    = tdata_q;
    assign o_tvalid   = tvalid_q;
    assign o_tlast    = tlast_q;
    assign o_level    = fifo_count;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_fog_readout_streamer.sv
// Directed bench for fog_readout_streamer (default 4-word frames).
// Table-driven single-frame check plus multi-cycle corner sequences.
module tb_fog_readout_streamer;
    import fog_rdout_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] dec = '0;
    logic        trig = 1'b0;
    logic [31:0] err = '0, step = '0, ramp = '0;
    logic [31:0] tdata;
    logic        tvalid, tlast;
    logic        tready = 1'b0;
    logic [3:0]  level;
    logic [15:0] drop;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wq[$];
    logic        lq[$];

    fog_readout_streamer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dec(dec), .i_trig(trig),
        .i_err(err), .i_step(step), .i_ramp(ramp),
        .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
        .o_tlast(tlast), .o_level(level), .o_drop_cnt(drop)
    );

    always #5 clk = ~clk;

    // Record every accepted stream word
    always @(posedge clk) begin
        if (!rst && tvalid && tready) begin
            wq.push_back(tdata);
            lq.push_back(tlast);
        end
    end

    typedef struct {
        logic        trig;
        logic [31:0] err, step, ramp;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [3:0]  elvl;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] getw(input int i);
        if (i < wq.size()) return wq[i];
        return 'x;
    endfunction

    function automatic logic getl(input int i);
        if (i < lq.size()) return lq[i];
        return 1'bx;
    endfunction

    task automatic chk_frame(input string nm, input int idx,
                             input logic [31:0] h, e, s, r);
        chk({nm, "_hdr"}, getw(idx), h);
        chk({nm, "_err"}, getw(idx + 1), e);
        chk({nm, "_step"}, getw(idx + 2), s);
        chk({nm, "_ramp"}, getw(idx + 3), r);
        chk({nm, "_last"}, 32'(getl(idx + 3)), 32'd1);
    endtask

    task automatic wait_words(input string nm, input int n, input int budget);
        int c = 0;
        while (wq.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk({nm, "_count"}, 32'(wq.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        trig = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] e, s, r);
        @(negedge clk);
        trig = 1'b1;
        err = e;
        step = s;
        ramp = r;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        int base;
        int found;
        logic pv, pr;
        logic [31:0] pd;

        tbl[0] = '{1'b1, 32'd5, 32'hFFFFFFFD, 32'h1000, 1'b1,
                   1'b0, 32'h0, 1'b0, 4'd1};
        tbl[1] = '{1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 1'b1,
                   1'b1, 32'hA5000000, 1'b0, 4'd1};
        tbl[2] = '{1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 1'b1,
                   1'b1, 32'd5, 1'b0, 4'd1};
        tbl[3] = '{1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 1'b1,
                   1'b1, 32'hFFFFFFFD, 1'b0, 4'd1};
        tbl[4] = '{1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 1'b1,
                   1'b1, 32'h1000, 1'b1, 4'd1};
        tbl[5] = '{1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 1'b1,
                   1'b0, 32'h0, 1'b0, 4'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        // Single frame, cycle by cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            trig = tbl[i].trig;
            err = tbl[i].err;
            step = tbl[i].step;
            ramp = tbl[i].ramp;
            tready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(tvalid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_data", i), tdata, tbl[i].ed);
            chk($sformatf("v%0d_last", i), 32'(tlast), 32'(tbl[i].el));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].elvl));
        end

        // Decimation by 3
        do_reset();
        dec = 16'd2;
        tready = 1'b1;
        base = wq.size();
        for (int k = 1; k <= 9; k++) begin
            pulse(32'(k), 32'(k + 100), 32'(k + 200));
            repeat (5) @(negedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("dec_words", 32'(wq.size() - base), 32'd12);
        for (int f = 0; f < 3; f++)
            chk_frame($sformatf("dec_f%0d", f), base + 4 * f,
                      32'hA5000000 | 32'(f), 32'(1 + 3 * f),
                      32'(101 + 3 * f), 32'(201 + 3 * f));
        dec = 16'd0;

        // Backpressure: tready toggles every cycle
        do_reset();
        tready = 1'b0;
        base = wq.size();
        @(negedge clk);
        trig = 1'b1;
        err = 32'd11; step = 32'd12; ramp = 32'd13;
        @(negedge clk);
        err = 32'd21; step = 32'd22; ramp = 32'd23;
        @(negedge clk);
        trig = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tready = c[0];
            pv = tvalid;
            pd = tdata;
            pr = tready;
            @(posedge clk);
            #1;
            if (pv && !pr) begin
                chk($sformatf("bp_hold_v%0d", c), 32'(tvalid), 32'd1);
                chk($sformatf("bp_hold_d%0d", c), tdata, pd);
            end
        end
        @(negedge clk);
        tready = 1'b1;
        wait_words("bp", base + 8, 20);
        chk_frame("bp_f0", base, 32'hA5000000, 32'd11, 32'd12, 32'd13);
        chk_frame("bp_f1", base + 4, 32'hA5000001, 32'd21, 32'd22, 32'd23);

        // Overflow: 10 captures into a stalled 8-deep FIFO
        do_reset();
        tready = 1'b0;
        base = wq.size();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            trig = 1'b1;
            err = 32'h100 + 32'(k);
            step = 32'h200 + 32'(k);
            ramp = 32'h300 + 32'(k);
        end
        @(negedge clk);
        trig = 1'b0;
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_drop", 32'(drop), 32'd2);
        tready = 1'b1;
        wait_words("ovf_drain", base + 32, 100);
        for (int k = 0; k < 8; k++)
            chk_frame($sformatf("ovf_f%0d", k), base + 4 * k,
                      32'hA5000000 | 32'(k), 32'h100 + 32'(k),
                      32'h200 + 32'(k), 32'h300 + 32'(k));
        repeat (3) @(negedge clk);
        pulse(32'h999, 32'h998, 32'h997);
        wait_words("ovf_ninth", base + 36, 40);
        chk_frame("ovf_f8", base + 32, 32'hA5800008,
                  32'h999, 32'h998, 32'h997);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_level_end", 32'(level), 32'd0);
        chk("ovf_drop_end", 32'(drop), 32'd2);

        // Capture on the last-word handshake while full
        do_reset();
        tready = 1'b0;
        base = wq.size();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            trig = 1'b1;
            err = 32'h400 + 32'(k);
            step = 32'h500 + 32'(k);
            ramp = 32'h600 + 32'(k);
        end
        @(negedge clk);
        trig = 1'b0;
        chk("sim_level_full", 32'(level), 32'd8);
        tready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (tvalid && tlast) begin
                trig = 1'b1;
                err = 32'h4FF; step = 32'h5FF; ramp = 32'h6FF;
                found = 1;
            end
        end
        chk("sim_found", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        chk("sim_level", 32'(level), 32'd8);
        chk("sim_drop", 32'(drop), 32'd0);
        @(negedge clk);
        trig = 1'b0;
        wait_words("sim_drain", base + 36, 100);
        chk_frame("sim_f0", base, 32'hA5000000, 32'h400, 32'h500, 32'h600);
        chk_frame("sim_f8", base + 32, 32'hA5000008,
                  32'h4FF, 32'h5FF, 32'h6FF);

        // Reset asserted mid-frame (in W_STEP)
        do_reset();
        tready = 1'b1;
        @(negedge clk);
        trig = 1'b1;
        err = 32'h31; step = 32'h32; ramp = 32'h33;
        @(negedge clk);
        err = 32'h41; step = 32'h42; ramp = 32'h43;
        @(negedge clk);
        trig = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_step_word", tdata, 32'h32);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = wq.size();
        pulse(32'h51, 32'h52, 32'h53);
        wait_words("mid_after", base + 4, 20);
        chk_frame("mid_f0", base, 32'hA5000000, 32'h51, 32'h52, 32'h53);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
